mel_filterbank: RTL and testbench

- Consumes the per-bin power values produced by the power stage (signed 32-bit, one bin per accepted beat).
- Applies NUM_FILTERS overlapping triangular filters on a uniform bin grid and emits one 32-bit filter energy per filter to the downstream log stage.
- Triangle weights are generated by counters, so no coefficient ROM is needed.
- Valid/ready on both sides; this stage back-pressures the power stage only when its output register is blocked.

---
 rtl/mel_filterbank.sv | 118 +++++++++++
 tb/tb_mel_filterbank.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mel_filterbank.sv
// Triangular mel filterbank: clamps each power bin to >= 0 and folds it into two
// running triangle accumulators whose weights come straight from the bin counter.
module mel_filterbank #(
    parameter int NUM_BINS    = 129,
    parameter int HOP_LOG2    = 4,
    parameter int NUM_FILTERS = 7,
    parameter int ACC_W       = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic [31:0] mel_out,
    output logic [7:0]  mel_idx,
    output logic        mel_last,
    output logic        mel_valid,
    input  logic        mel_ready
);
    localparam int H  = 1 << HOP_LOG2;
    localparam int BW = $clog2(NUM_BINS + 1);
    localparam int SW = BW - HOP_LOG2;
    localparam logic [BW-1:0] ACC_END  = BW'((NUM_FILTERS + 1) * H);
    localparam logic [BW-1:0] LAST_BIN = BW'(NUM_BINS - 1);
    localparam logic [SW-1:0] SEG_NF   = SW'(NUM_FILTERS);
    localparam logic [SW-1:0] SEG_LAST = SW'(NUM_FILTERS + 1);

    if ((NUM_FILTERS + 1) * H >= NUM_BINS + 1) begin : g_param_check
        $error("mel_filterbank: (NUM_FILTERS+1)*H must be below NUM_BINS+1");
    end

    typedef enum logic {ACC, TAIL} state_t;

    state_t              state, state_next;
    logic [BW-1:0]       bin, bin_next;
    logic [SW-1:0]       seg;
    logic [HOP_LOG2-1:0] pos;
    logic [ACC_W-1:0]    acc_rise, acc_fall;
    logic [ACC_W-1:0]    x, rise_term, fall_term, peak_term, fall_scaled;
    logic                emit_slot, accept, sat_hit;

    assign seg         = bin[BW-1:HOP_LOG2];
    assign pos         = bin[HOP_LOG2-1:0];
    assign x           = data_in[31] ? '0 : {{(ACC_W-32){1'b0}}, data_in};
    assign rise_term   = x * {{(ACC_W-HOP_LOG2){1'b0}}, pos};
    assign fall_term   = x * (ACC_W'(H) - {{(ACC_W-HOP_LOG2){1'b0}}, pos});
    assign peak_term   = x << HOP_LOG2;
    assign fall_scaled = acc_fall >> HOP_LOG2;
    assign sat_hit     = |fall_scaled[ACC_W-1:31];

    // Only a bin that would overwrite a still-blocked result has to wait.
    assign emit_slot  = (state == ACC) && (pos == '0) && (seg >= SW'(2));
    assign data_ready = !(mel_valid && !mel_ready && emit_slot);
    assign accept     = data_valid && data_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ACC;
            bin   <= '0;
        end else begin
            state <= state_next;
            bin   <= bin_next;
        end
    end

    always_comb begin
        state_next = state;
        bin_next   = bin;
        if (accept) begin
            bin_next = bin + BW'(1);
            if (bin == LAST_BIN) begin
                bin_next   = '0;
                state_next = ACC;
            end else if (state == ACC && bin == ACC_END) begin
                state_next = TAIL;
            end
        end
    end

    // acc_rise builds filter s on its rising edge; acc_fall finishes filter s-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_rise <= '0;
            acc_fall <= '0;
        end else if (accept) begin
            if (state == TAIL) begin
                if (bin == LAST_BIN) begin
                    acc_rise <= '0;
                    acc_fall <= '0;
                end
            end else if (pos != '0) begin
                if (seg >= SW'(1))
                    acc_fall <= acc_fall + fall_term;
                if (seg < SEG_NF)
                    acc_rise <= acc_rise + rise_term;
            end else begin
                acc_fall <= (seg <= SEG_NF) ? acc_rise + peak_term : '0;
                acc_rise <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mel_out   <= '0;
            mel_idx   <= '0;
            mel_last  <= 1'b0;
            mel_valid <= 1'b0;
        end else if (accept && emit_slot) begin
            mel_out   <= sat_hit ? 32'h7FFF_FFFF : fall_scaled[31:0];
            mel_idx   <= 8'(seg - SW'(2));
            mel_last  <= (seg == SEG_LAST);
            mel_valid <= 1'b1;
        end else if (mel_ready) begin
            mel_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mel_filterbank.sv
// Bench for mel_filterbank: table-driven frames plus stall, mid-frame reset and
// back-to-back sequences, checked through a scoreboard of expected filter results.
module tb_mel_filterbank;
    localparam int NUM_BINS    = 129;
    localparam int HOP_LOG2    = 4;
    localparam int NUM_FILTERS = 7;
    localparam int H           = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic [31:0] mel_out;
    logic [7:0]  mel_idx;
    logic        mel_last;
    logic        mel_valid;
    logic        mel_ready;

    mel_filterbank #(
        .NUM_BINS(NUM_BINS), .HOP_LOG2(HOP_LOG2), .NUM_FILTERS(NUM_FILTERS), .ACC_W(48)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .mel_out(mel_out), .mel_idx(mel_idx),
        .mel_last(mel_last), .mel_valid(mel_valid), .mel_ready(mel_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] out;
        logic [7:0]  idx;
        logic        last;
        logic [31:0] bin;
    } exp_t;

    typedef struct packed {
        logic        impulse;
        logic [31:0] value;
        logic [7:0]  imp_bin;
        logic [31:0] exp_lo;
        logic [31:0] exp_mid;
        logic [31:0] exp_hi;
    } vec_t;

    int                compared = 0;
    int                mismatched = 0;
    int                cur_bin = 0;
    exp_t              exp_q[$];
    logic signed [31:0] frame_buf [NUM_BINS];

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
        end
    endtask

    // Present one bin from a falling edge and return on the falling edge after it is taken.
    task automatic apply_stimulus(input logic [31:0] value);
        logic was_ready;
        int   guard;
        data_in    = value;
        data_valid = 1'b1;
        guard      = 0;
        do begin
            #1;
            was_ready = data_ready;
            @(negedge clk);
            guard++;
        end while (!was_ready && guard < 1000);
        if (!was_ready) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL data_ready_timeout: bin %0d not accepted, required acceptance within 1000 cycles", cur_bin);
        end
    endtask

    task automatic send_frame(input int count);
        for (int b = 0; b < count; b++) begin
            cur_bin = b;
            apply_stimulus(frame_buf[b]);
        end
    endtask

    task automatic push_expected(input int k, input logic [31:0] value);
        exp_t e;
        e.out  = value;
        e.idx  = 8'(k);
        e.last = (k == NUM_FILTERS - 1);
        e.bin  = 32'((k + 2) * H);
        exp_q.push_back(e);
    endtask

    task automatic fill_const(input logic [31:0] value);
        for (int b = 0; b < NUM_BINS; b++)
            frame_buf[b] = value;
    endtask

    // Reference triangle: 0 at kH, peak H at (k+1)H, back to 0 at (k+2)H.
    function automatic logic [31:0] model_mel(input int k);
        longint sum;
        longint xv;
        int     lo, pk, hi, w;
        sum = 0;
        lo  = k * H;
        pk  = lo + H;
        hi  = pk + H;
        for (int b = 0; b < NUM_BINS; b++) begin
            xv = (frame_buf[b] < 0) ? 0 : longint'(frame_buf[b]);
            if (b >= lo && b <= pk)     w = b - lo;
            else if (b > pk && b < hi)  w = hi - b;
            else                        w = 0;
            sum += longint'(w) * xv;
        end
        sum = sum >>> HOP_LOG2;
        return (sum > 64'h7FFF_FFFF) ? 32'h7FFF_FFFF : 32'(sum);
    endfunction

    // Hold the output blocked for 40 cycles right after the first result of the frame.
    task automatic stall_seq();
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            #1;
            guard++;
        end while (!(mel_valid && mel_idx == 8'd0 && cur_bin == 33) && guard < 500);
        if (guard >= 500) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL stall_start_timeout: idx0 result at bin 33 not seen, required within 500 cycles");
        end
        mel_ready = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 20) begin
                #1;
                check_output("stall_blocked_bin", 64'(cur_bin), 64'd48);
                check_output("stall_data_ready", {63'd0, data_ready}, 64'd0);
                check_output("stall_mel_valid", {63'd0, mel_valid}, 64'd1);
            end
        end
        mel_ready = 1'b1;
    endtask

    // Scoreboard monitor, sampled in the quiet part of the low clock phase.
    initial begin
        exp_t        e;
        logic        prev_valid, prev_ready;
        logic [31:0] held_out;
        logic [7:0]  held_idx;
        logic        held_last;
        int          last_acc_bin;
        prev_valid   = 1'b0;
        prev_ready   = 1'b0;
        held_out     = '0;
        held_idx     = '0;
        held_last    = 1'b0;
        last_acc_bin = -1;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                prev_valid = 1'b0;
                prev_ready = 1'b0;
            end else begin
                if (mel_valid && (!prev_valid || prev_ready)) begin
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL unexpected_output: idx %0d value 0x%0h, required no output", mel_idx, mel_out);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("mel_out", 64'(mel_out), 64'(e.out));
                        check_output("mel_idx", 64'(mel_idx), 64'(e.idx));
                        check_output("mel_last", {63'd0, mel_last}, {63'd0, e.last});
                        check_output("emit_bin", 64'(last_acc_bin), 64'(e.bin));
                    end
                end else if (mel_valid && prev_valid && !prev_ready) begin
                    check_output("hold_out", 64'(mel_out), 64'(held_out));
                    check_output("hold_idx", 64'(mel_idx), 64'(held_idx));
                    check_output("hold_last", {63'd0, mel_last}, {63'd0, held_last});
                end
                held_out   = mel_out;
                held_idx   = mel_idx;
                held_last  = mel_last;
                prev_valid = mel_valid;
                prev_ready = mel_ready;
                if (data_valid && data_ready)
                    last_acc_bin = cur_bin;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vectors [4];
        vectors[0] = '{1'b0, 32'd1024,       8'd0,  32'd16384,      32'd16384,      32'd16384};
        vectors[1] = '{1'b1, 32'd4096,       8'd24, 32'd2048,       32'd2048,       32'd0};
        vectors[2] = '{1'b0, 32'h7FFF_FFFF,  8'd0,  32'h7FFF_FFFF,  32'h7FFF_FFFF,  32'h7FFF_FFFF};
        vectors[3] = '{1'b0, 32'hFFFF_FFFB,  8'd0,  32'd0,          32'd0,          32'd0};

        rst        = 1'b0;
        data_in    = '0;
        data_valid = 1'b0;
        mel_ready  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_output("reset_mel_out", 64'(mel_out), 64'd0);
        check_output("reset_mel_idx", 64'(mel_idx), 64'd0);
        check_output("reset_mel_last", {63'd0, mel_last}, 64'd0);
        check_output("reset_mel_valid", {63'd0, mel_valid}, 64'd0);
        check_output("reset_data_ready", {63'd0, data_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < NUM_BINS; b++) begin
                if (vectors[i].impulse)
                    frame_buf[b] = (b == int'(vectors[i].imp_bin)) ? vectors[i].value : 32'd0;
                else
                    frame_buf[b] = vectors[i].value;
            end
            push_expected(0, vectors[i].exp_lo);
            push_expected(1, vectors[i].exp_mid);
            for (int k = 2; k < NUM_FILTERS; k++)
                push_expected(k, vectors[i].exp_hi);
            send_frame(NUM_BINS);
        end

        $display("[TB] random frame against triangle model");
        for (int b = 0; b < NUM_BINS; b++) begin
            if (b % 7 == 3)
                frame_buf[b] = -$signed({1'b0, 31'($urandom_range(1, 1000))});
            else
                frame_buf[b] = $signed({1'b0, 31'($urandom_range(0, 2000000))});
        end
        for (int k = 0; k < NUM_FILTERS; k++)
            push_expected(k, model_mel(k));
        send_frame(NUM_BINS);

        $display("[TB] output stall after idx0");
        fill_const(32'd1024);
        for (int k = 0; k < NUM_FILTERS; k++)
            push_expected(k, 32'd16384);
        fork
            send_frame(NUM_BINS);
            stall_seq();
        join

        $display("[TB] reset in the middle of a frame");
        for (int k = 0; k < 3; k++)
            push_expected(k, 32'd16384);
        send_frame(71);
        data_valid = 1'b0;
        rst        = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_output("midreset_queue", 64'(exp_q.size()), 64'd0);
        check_output("midreset_mel_valid", {63'd0, mel_valid}, 64'd0);
        check_output("midreset_data_ready", {63'd0, data_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < NUM_FILTERS; k++)
            push_expected(k, 32'd16384);
        send_frame(NUM_BINS);

        $display("[TB] back-to-back frames");
        data_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NUM_FILTERS; k++)
            push_expected(k, 32'd16384);
        send_frame(NUM_BINS);
        fill_const(32'd2048);
        for (int k = 0; k < NUM_FILTERS; k++)
            push_expected(k, 32'd32768);
        send_frame(NUM_BINS);

        data_valid = 1'b0;
        repeat (10) @(negedge clk);
        check_output("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
